// File: rtl/seq_divider_4_pkg.sv
// Shared definitions for the 4-bit sequential restoring divider:
// state encoding, datapath width and divide-by-zero constants.
package seq_divider_4_pkg;

  localparam int WIDTH = 4;
  localparam int COUNT_W = 2;
  localparam logic [COUNT_W-1:0] COUNT_INIT = 2'd3;
  localparam logic [WIDTH-1:0] DBZ_QUOTIENT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_4_if.sv
// Request/result bundle of the sequential divider; the master issues
// operands, the slave (divider) returns status and results.
interface seq_divider_4_if;
  import seq_divider_4_pkg::*;

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_4_add_sub_unit.sv
// Ripple-carry add/subtract: m=0 gives a+b, m=1 gives a-b with carry_out=1
// meaning no borrow (a >= b).
module add_sub_unit
  import seq_divider_4_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] b_eff;

  // Subtraction is a + ~b + 1, the +1 entering as the initial carry.
  assign carry[0] = m;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign b_eff[gi]    = b[gi] ^ m;
      assign result[gi]   = a[gi] ^ b_eff[gi] ^ carry[gi];
      assign carry[gi+1]  = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
    end
  endgenerate

  assign carry_out = carry[WIDTH];

endmodule

// File: rtl/seq_divider_4.sv
// 4-bit unsigned restoring divider: one shift-subtract step per clock on a
// shared add/subtract unit, done pulse with quotient/remainder after 5 cycles.
module seq_divider_4
  import seq_divider_4_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  seq_divider_4_if.slave  bus
);

  state_t             state_reg;
  logic [WIDTH-2:0]   r_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [WIDTH-1:0]   d_reg;
  logic [COUNT_W-1:0] count_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   quotient_reg;
  logic [WIDTH-1:0]   remainder_reg;
  logic               dbz_reg;

  logic [WIDTH-1:0]   trial;
  logic [WIDTH-1:0]   diff;
  logic               no_borrow;
  logic [WIDTH-1:0]   r_next;
  logic [WIDTH-1:0]   q_next;

  // The partial remainder stays below 8 until the last shift, so three
  // stored bits suffice and the shifted trial value fits in four.
  assign trial  = {r_reg, q_reg[WIDTH-1]};
  assign r_next = no_borrow ? diff : trial;
  assign q_next = {q_reg[WIDTH-2:0], no_borrow};

  add_sub_unit u_add_sub (
    .a         (trial),
    .b         (d_reg),
    .m         (1'b1),
    .result    (diff),
    .carry_out (no_borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      r_reg         <= '0;
      q_reg         <= '0;
      d_reg         <= '0;
      count_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        ST_IDLE, ST_DONE: begin
          state_reg <= ST_IDLE;
          if (bus.start) begin
            if (bus.divisor != '0) begin
              r_reg     <= '0;
              q_reg     <= bus.dividend;
              d_reg     <= bus.divisor;
              count_reg <= COUNT_INIT;
              dbz_reg   <= 1'b0;
              busy_reg  <= 1'b1;
              state_reg <= ST_RUN;
            end else begin
              quotient_reg  <= DBZ_QUOTIENT;
              remainder_reg <= bus.dividend;
              dbz_reg       <= 1'b1;
              done_reg      <= 1'b1;
              state_reg     <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          r_reg     <= r_next[WIDTH-2:0];
          q_reg     <= q_next;
          count_reg <= count_reg - 1'b1;
          if (count_reg == '0) begin
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            quotient_reg  <= q_next;
            remainder_reg <= r_next;
            state_reg     <= ST_DONE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider_4.sv
// Scoreboard bench for seq_divider_4: expected results are queued when a
// request is issued and compared when done pulses.
module tb_seq_divider_4;
  import seq_divider_4_pkg::*;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  seq_divider_4_if bus ();

  seq_divider_4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q = 4'hF; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge: presents a request for the next rising edge (edge 0).
  task automatic drive_start(input logic [3:0] a, input logic [3:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dbz=%b, required all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL reset_start_dropped: got busy=%b done=%b, required 0 0", bus.busy, bus.done);
      end
    end
    $display("txn reset with start held: outputs idle");
  endtask

  task automatic test_basic();
    exp_t e;
    @(negedge clk);
    drive_start(4'd13, 4'd3);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== (k <= 4)) begin
        errors++;
        $display("FAIL basic_busy cycle %0d: got %b, required %b", k, bus.busy, (k <= 4));
      end
      checks++;
      if (bus.done !== (k == 5)) begin
        errors++;
        $display("FAIL basic_done cycle %0d: got %b, required %b", k, bus.done, (k == 5));
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz) begin
      errors++;
      $display("FAIL basic_result 13/3: got q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
               bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
    end
    $display("txn 13/3 -> q=%0d r=%0d dbz=%b", bus.quotient, bus.remainder, bus.div_by_zero);
  endtask

  task automatic test_values();
    logic [3:0] ta [3] = '{4'd15, 4'd7, 4'd15};
    logic [3:0] tb [3] = '{4'd1, 4'd9, 4'd15};
    exp_t e;
    int   lat;
    bit   found;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_start(ta[i], tb[i]);
      lat = 0; found = 1'b0;
      while (lat < 10 && !found) begin
        @(negedge clk);
        lat++;
        if (bus.done === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found || lat != 5) begin
        errors++;
        $display("FAIL values_latency %0d/%0d: got %0d cycles (found=%b), required 5", ta[i], tb[i], lat, found);
      end
      if (found) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz) begin
          errors++;
          $display("FAIL values_result %0d/%0d: got q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
                   ta[i], tb[i], bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
        end
      end else begin
        exp_q.delete();
      end
      $display("txn %0d/%0d -> q=%0d r=%0d dbz=%b", ta[i], tb[i], bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_div_zero();
    exp_t e;
    @(negedge clk);
    drive_start(4'd14, 4'd0);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL dbz_cycle1: got done=%b busy=%b, required done=1 busy=0", bus.done, bus.busy);
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz) begin
      errors++;
      $display("FAIL dbz_result 14/0: got q=%h r=%0d dbz=%b, required q=%h r=%0d dbz=%b",
               bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
    end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.div_by_zero !== 1'b1) begin
        errors++;
        $display("FAIL dbz_after cycle %0d: got done=%b busy=%b dbz=%b, required 0 0 1",
                 k, bus.done, bus.busy, bus.div_by_zero);
      end
    end
    $display("txn 14/0 -> q=%h r=%0d dbz=%b", bus.quotient, bus.remainder, bus.div_by_zero);
  endtask

  task automatic test_sweep();
    exp_t       e;
    int         next;
    int         completed;
    int         lat;
    int         want_lat;
    logic [3:0] cur_a;
    logic [3:0] cur_b;
    @(negedge clk);
    cur_a = 4'd0; cur_b = 4'd0;
    drive_start(cur_a, cur_b);
    next = 1; completed = 0; lat = 0;
    while (completed < 256) begin
      @(negedge clk);
      lat++;
      if (bus.done === 1'b1) begin
        want_lat = (cur_b == 4'd0) ? 1 : 5;
        checks++;
        if (lat != want_lat) begin
          errors++;
          $display("FAIL sweep_latency %0d/%0d: got %0d, required %0d", cur_a, cur_b, lat, want_lat);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sweep_unexpected_done: got done with empty scoreboard, required none");
        end else begin
          e = exp_q.pop_front();
          if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz) begin
            errors++;
            $display("FAIL sweep_result %0d/%0d: got q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
                     cur_a, cur_b, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
          end
        end
        $display("txn %0d/%0d -> q=%0d r=%0d dbz=%b", cur_a, cur_b, bus.quotient, bus.remainder, bus.div_by_zero);
        completed++;
        if (next < 256) begin
          cur_a = next[7:4];
          cur_b = next[3:0];
          next++;
          lat = 0;
          drive_start(cur_a, cur_b);
        end
      end else if (lat > 8) begin
        checks++;
        errors++;
        $display("FAIL sweep_timeout %0d/%0d: got no done in %0d cycles, required done", cur_a, cur_b, lat);
        exp_q.delete();
        break;
      end
    end
  endtask

  task automatic test_ignore_busy();
    exp_t e;
    @(negedge clk);
    drive_start(4'd9, 4'd2);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd6; bus.divisor = 4'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== (k <= 4) || bus.done !== (k == 5)) begin
        errors++;
        $display("FAIL ignore_timing cycle %0d: got busy=%b done=%b, required busy=%b done=%b",
                 k, bus.busy, bus.done, (k <= 4), (k == 5));
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz) begin
      errors++;
      $display("FAIL ignore_result 9/2: got q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
               bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
    end
    for (int k = 6; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== e.q || bus.remainder !== e.r) begin
        errors++;
        $display("FAIL ignore_hold cycle %0d: got done=%b busy=%b q=%0d r=%0d, required 0 0 %0d %0d",
                 k, bus.done, bus.busy, bus.quotient, bus.remainder, e.q, e.r);
      end
    end
    $display("txn 9/2 (6/3 ignored) -> q=%0d r=%0d dbz=%b", bus.quotient, bus.remainder, bus.div_by_zero);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    bit   found;
    @(negedge clk);
    drive_start(4'd12, 4'd5);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 11'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b, required all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset_no_done: got done=%b busy=%b, required 0 0", bus.done, bus.busy);
      end
    end
    $display("txn 12/5 aborted by reset");
    @(negedge clk);
    drive_start(4'd12, 4'd5);
    lat = 0; found = 1'b0;
    while (lat < 10 && !found) begin
      @(negedge clk);
      lat++;
      if (bus.done === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || lat != 5) begin
      errors++;
      $display("FAIL midreset_latency: got %0d cycles (found=%b), required 5", lat, found);
    end
    if (found) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz) begin
        errors++;
        $display("FAIL midreset_result 12/5: got q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
                 bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
      end
    end else begin
      exp_q.delete();
    end
    $display("txn 12/5 -> q=%0d r=%0d dbz=%b", bus.quotient, bus.remainder, bus.div_by_zero);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = 4'd0;
    bus.divisor  = 4'd0;
    rst          = 1'b1;
    test_reset();
    test_basic();
    test_values();
    test_div_zero();
    test_sweep();
    test_ignore_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
